// File: rtl/inst_loader.sv
// inst_loader: byte-stream program loader. Receives a little-endian 16-bit
// word count followed by two bytes per instruction word. Each pair of bytes
// is packed into a W-bit word and written to instruction RAM at consecutive
// addresses starting at 0. The core is held in reset while a load is running.
module inst_loader #(
    parameter int A = 10,
    parameter int W = 9
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Start,
    input  logic [7:0]   InByte,
    input  logic         InValid,
    output logic         InReady,
    output logic         WrEn,
    output logic [A-1:0] WrAddr,
    output logic [W-1:0] WrData,
    output logic         CpuHold,
    output logic         Done,
    output logic         Err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CNT_LO,
        S_CNT_HI,
        S_DAT_LO,
        S_DAT_HI,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    // The remaining-word counter must hold the full count 2**A.
    localparam int          RW        = A + 1;
    localparam logic [16:0] MAX_WORDS = 17'(1) << A;

    state_t          state_q, state_d;
    logic [A-1:0]    addr_q,  addr_d;
    logic [W-1:0]    data_q,  data_d;
    logic [7:0]      lo_q,    lo_d;
    logic [RW-1:0]   rem_q,   rem_d;

    logic            xfer;
    logic [15:0]     len_w;

    assign xfer  = InValid & InReady;
    assign len_w = {InByte, lo_q};

    // Next-state logic: walk the stream format and launch one write per word pair.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        lo_d    = lo_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (Start) begin
                    state_d = S_CNT_LO;
                    addr_d  = '0;
                end
            end
            S_CNT_LO: begin
                if (xfer) begin
                    lo_d    = InByte;
                    state_d = S_CNT_HI;
                end
            end
            S_CNT_HI: begin
                if (xfer) begin
                    if (len_w == 16'd0) begin
                        state_d = S_DONE;
                    end else if ({1'b0, len_w} > MAX_WORDS) begin
                        state_d = S_ERR;
                    end else begin
                        rem_d   = len_w[RW-1:0];
                        state_d = S_DAT_LO;
                    end
                end
            end
            S_DAT_LO: begin
                if (xfer) begin
                    lo_d    = InByte;
                    state_d = S_DAT_HI;
                end
            end
            S_DAT_HI: begin
                if (xfer) begin
                    // Upper bits of the high byte beyond the word width are dropped.
                    data_d  = {InByte[W-9:0], lo_q};
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // Address wrap after the last word of a full-size load is harmless:
                // the loader parks in DONE and issues no further writes.
                addr_d  = addr_q + 1'b1;
                rem_d   = rem_q - 1'b1;
                state_d = (rem_q == RW'(1)) ? S_DONE : S_DAT_LO;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode: every strobe and status flag is a pure function of state.
    always_comb begin
        InReady = (state_q == S_CNT_LO) || (state_q == S_CNT_HI) ||
                  (state_q == S_DAT_LO) || (state_q == S_DAT_HI);
        WrEn    = (state_q == S_WRITE);
        CpuHold = InReady || (state_q == S_WRITE);
        Done    = (state_q == S_DONE);
        Err     = (state_q == S_ERR);
        WrAddr  = addr_q;
        WrData  = data_q;
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            lo_q    <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            lo_q    <= lo_d;
            rem_q   <= rem_d;
        end
    end

endmodule
